// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the multi-cycle RV32M/RV64M multiply/divide unit.
// Optional result cache in muldiv_unit is enabled by defining MULDIV_RESULT_CACHE_EN.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } muldiv_state_e;

  // Counter sized for the widest supported XLEN so both RV32 and RV64 fit.
  localparam int XLEN_MAX  = 64;
  localparam int DIV_CNT_W = $clog2(XLEN_MAX + 1);

  function automatic logic is_signed_div(input logic [2:0] op);
    return op[2] & ~op[0];
  endfunction

  // Product signedness class: 2'b01 ss, 2'b10 su, 2'b11 uu (MUL is formed as uu).
  function automatic logic [1:0] mul_class(input logic [2:0] op);
    logic [1:0] cls;
    if (op[1:0] == 2'b00) cls = 2'b11;
    else cls = op[1:0];
    return cls;
  endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Unsigned radix-2 restoring divider: one quotient bit per cycle, done after XLEN iterations.
module muldiv_divider
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [DIV_CNT_W-1:0] cnt_r;
  logic                 busy_r;
  logic [XLEN-1:0]      quo_r, rem_r, dvs_r;
  logic [XLEN:0]        shifted_s, diff_s;

  // Trial subtraction; a clear sign bit means the divisor fits.
  always_comb begin
    shifted_s = {rem_r, quo_r[XLEN-1]};
    diff_s    = shifted_s - {1'b0, dvs_r};
    done      = busy_r && (cnt_r == {DIV_CNT_W{1'b0}});
    quotient  = quo_r;
    remainder = rem_r;
  end

  // Iteration state; busy drops on the cycle the result is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
      cnt_r  <= {DIV_CNT_W{1'b0}};
      quo_r  <= {XLEN{1'b0}};
      rem_r  <= {XLEN{1'b0}};
      dvs_r  <= {XLEN{1'b0}};
    end else if (abort) begin
      busy_r <= 1'b0;
      cnt_r  <= {DIV_CNT_W{1'b0}};
    end else if (start) begin
      busy_r <= 1'b1;
      cnt_r  <= DIV_CNT_W'(XLEN);
      quo_r  <= dividend;
      rem_r  <= {XLEN{1'b0}};
      dvs_r  <= divisor;
    end else if (busy_r && (cnt_r != {DIV_CNT_W{1'b0}})) begin
      cnt_r <= cnt_r - DIV_CNT_W'(1);
      if (!diff_s[XLEN]) begin
        rem_r <= diff_s[XLEN-1:0];
        quo_r <= {quo_r[XLEN-2:0], 1'b1};
      end else begin
        rem_r <= shifted_s[XLEN-1:0];
        quo_r <= {quo_r[XLEN-2:0], 1'b0};
      end
    end else if (busy_r) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= 1'b0;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M/RV64M execute unit: pipelined multiply, restoring divide, one op in flight.
// Define MULDIV_RESULT_CACHE_EN to add a last-result cache giving one-cycle repeat ops.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2,
  parameter int TAG_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             kill,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_op1,
  input  logic [XLEN-1:0]  in_op2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  muldiv_state_e     state_r, state_s;
  muldiv_op_e        op_in_s, op_r;
  logic              accept_s, done_s, fast_s, fast_r, mul_start_s, div_start_s;
  logic              sgn1_s, sgn2_s, sdiv_s, dvd_neg_s, dvs_neg_s, div0_s, ovf_s;
  logic              neg_q_r, neg_r_r, div_done_s, hit_s;
  logic [2*XLEN-1:0] a_ext_s, b_ext_s, prod_s, fin_prod_s, fast_prod_r, hit_prod_s;
  logic [2*XLEN-1:0] pipe_r [MUL_STAGES];
  logic [MUL_STAGES-1:0] pipe_vld_r;
  logic [XLEN-1:0]   dvd_mag_s, dvs_mag_s, spec_q_s, spec_r_s, hit_q_s, hit_r_s;
  logic [XLEN-1:0]   fast_q_r, fast_rm_r, div_q_s, div_r_s, fin_q_s, fin_r_s, res_s;
  logic [TAG_W-1:0]  tag_r;

  // Operand conditioning for both datapaths on the accept cycle.
  always_comb begin
    op_in_s   = muldiv_op_e'(in_op);
    accept_s  = in_valid && (state_r == ST_IDLE) && !kill;
    sgn1_s    = (op_in_s == OP_MULH) || (op_in_s == OP_MULHSU);
    sgn2_s    = (op_in_s == OP_MULH);
    a_ext_s   = {{XLEN{in_op1[XLEN-1] & sgn1_s}}, in_op1};
    b_ext_s   = {{XLEN{in_op2[XLEN-1] & sgn2_s}}, in_op2};
    prod_s    = a_ext_s * b_ext_s;
    sdiv_s    = is_signed_div(in_op);
    dvd_neg_s = sdiv_s & in_op1[XLEN-1];
    dvs_neg_s = sdiv_s & in_op2[XLEN-1];
    dvd_mag_s = dvd_neg_s ? -in_op1 : in_op1;
    dvs_mag_s = dvs_neg_s ? -in_op2 : in_op2;
    div0_s    = (in_op2 == {XLEN{1'b0}});
    ovf_s     = sdiv_s && (in_op1 == {1'b1, {(XLEN-1){1'b0}}}) && (in_op2 == {XLEN{1'b1}});
    if (div0_s) begin
      spec_q_s = {XLEN{1'b1}};
      spec_r_s = in_op1;
    end else begin
      spec_q_s = in_op1;
      spec_r_s = {XLEN{1'b0}};
    end
    fast_s      = in_op[2] ? (div0_s || ovf_s || hit_s) : hit_s;
    mul_start_s = accept_s && !in_op[2] && !fast_s;
    div_start_s = accept_s && in_op[2] && !fast_s;
  end

  // Product pipeline; the valid bits follow the single in-flight multiply.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld_r <= {MUL_STAGES{1'b0}};
      for (int i = 0; i < MUL_STAGES; i++) pipe_r[i] <= {(2*XLEN){1'b0}};
    end else if (kill) begin
      pipe_vld_r <= {MUL_STAGES{1'b0}};
    end else begin
      pipe_vld_r[0] <= mul_start_s;
      pipe_r[0]     <= prod_s;
      for (int i = 1; i < MUL_STAGES; i++) begin
        pipe_vld_r[i] <= pipe_vld_r[i-1];
        pipe_r[i]     <= pipe_r[i-1];
      end
    end
  end

  muldiv_divider #(.XLEN(XLEN)) u_divider (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start_s),
    .abort     (kill),
    .dividend  (dvd_mag_s),
    .divisor   (dvs_mag_s),
    .done      (div_done_s),
    .quotient  (div_q_s),
    .remainder (div_r_s)
  );

  // Final result selection: fast-path values or the sign-fixed iterative result.
  always_comb begin
    if (fast_r) begin
      fin_prod_s = fast_prod_r;
      fin_q_s    = fast_q_r;
      fin_r_s    = fast_rm_r;
    end else begin
      fin_prod_s = pipe_r[MUL_STAGES-1];
      fin_q_s    = neg_q_r ? -div_q_s : div_q_s;
      fin_r_s    = neg_r_r ? -div_r_s : div_r_s;
    end
    case (op_r)
      OP_MUL:                       res_s = fin_prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res_s = fin_prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              res_s = fin_q_s;
      OP_REM, OP_REMU:              res_s = fin_r_s;
      default:                      res_s = {XLEN{1'b0}};
    endcase
  end

  // Per-operation context captured on accept, and the held output result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r        <= OP_MUL;
      tag_r       <= {TAG_W{1'b0}};
      fast_r      <= 1'b0;
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      fast_prod_r <= {(2*XLEN){1'b0}};
      fast_q_r    <= {XLEN{1'b0}};
      fast_rm_r   <= {XLEN{1'b0}};
      out_result  <= {XLEN{1'b0}};
      out_tag     <= {TAG_W{1'b0}};
    end else begin
      if (accept_s) begin
        op_r        <= op_in_s;
        tag_r       <= in_tag;
        fast_r      <= fast_s;
        neg_q_r     <= dvd_neg_s ^ dvs_neg_s;
        neg_r_r     <= dvd_neg_s;
        fast_prod_r <= hit_prod_s;
        fast_q_r    <= hit_s ? hit_q_s : spec_q_s;
        fast_rm_r   <= hit_s ? hit_r_s : spec_r_s;
      end
      if (done_s && !kill) begin
        out_result <= res_s;
        out_tag    <= tag_r;
      end
    end
  end

`ifdef MULDIV_RESULT_CACHE_EN
  logic [XLEN-1:0]   op1_r, op2_r, c_mop1_r, c_mop2_r, c_dop1_r, c_dop2_r, c_q_r, c_r_r;
  logic [2*XLEN-1:0] c_prod_r;
  logic [1:0]        cls_r, c_cls_r;
  logic              c_mvld_r, c_dvld_r, c_dsgn_r, mul_hit_s, div_hit_s;

  // MUL's low half is class-independent, so it may reuse any cached product.
  always_comb begin
    mul_hit_s  = c_mvld_r && (in_op1 == c_mop1_r) && (in_op2 == c_mop2_r) &&
                 ((op_in_s == OP_MUL) || (mul_class(in_op) == c_cls_r));
    div_hit_s  = c_dvld_r && (in_op1 == c_dop1_r) && (in_op2 == c_dop2_r) &&
                 (is_signed_div(in_op) == c_dsgn_r);
    hit_s      = in_op[2] ? div_hit_s : mul_hit_s;
    hit_prod_s = c_prod_r;
    hit_q_s    = c_q_r;
    hit_r_s    = c_r_r;
  end

  // Cache update on every completed op; kill drops both entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op1_r <= {XLEN{1'b0}}; op2_r <= {XLEN{1'b0}}; cls_r <= 2'b00;
      c_mop1_r <= {XLEN{1'b0}}; c_mop2_r <= {XLEN{1'b0}};
      c_dop1_r <= {XLEN{1'b0}}; c_dop2_r <= {XLEN{1'b0}};
      c_q_r <= {XLEN{1'b0}}; c_r_r <= {XLEN{1'b0}}; c_prod_r <= {(2*XLEN){1'b0}};
      c_cls_r <= 2'b00; c_mvld_r <= 1'b0; c_dvld_r <= 1'b0; c_dsgn_r <= 1'b0;
    end else if (kill) begin
      c_mvld_r <= 1'b0;
      c_dvld_r <= 1'b0;
    end else begin
      if (accept_s) begin
        op1_r <= in_op1;
        op2_r <= in_op2;
        cls_r <= mul_hit_s ? c_cls_r : mul_class(in_op);
      end
      if (done_s && op_r[2]) begin
        c_dvld_r <= 1'b1; c_dop1_r <= op1_r; c_dop2_r <= op2_r;
        c_q_r <= fin_q_s; c_r_r <= fin_r_s; c_dsgn_r <= is_signed_div(op_r);
      end else if (done_s) begin
        c_mvld_r <= 1'b1; c_mop1_r <= op1_r; c_mop2_r <= op2_r;
        c_prod_r <= fin_prod_s; c_cls_r <= cls_r;
      end
    end
  end
`else
  // No cache: every op takes its full latency.
  always_comb begin
    hit_s      = 1'b0;
    hit_prod_s = {(2*XLEN){1'b0}};
    hit_q_s    = {XLEN{1'b0}};
    hit_r_s    = {XLEN{1'b0}};
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else state_r <= state_s;
  end

  // Next-state logic; kill overrides every transition.
  always_comb begin
    case (state_r)
      ST_MUL:  done_s = fast_r || pipe_vld_r[MUL_STAGES-1];
      ST_DIV:  done_s = fast_r || div_done_s;
      default: done_s = 1'b0;
    endcase
    state_s = state_r;
    if (kill) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) state_s = in_op[2] ? ST_DIV : ST_MUL;
          else state_s = ST_IDLE;
        end
        ST_MUL, ST_DIV: begin
          if (done_s) state_s = ST_DONE;
          else state_s = state_r;
        end
        ST_DONE: begin
          if (out_ready) state_s = ST_IDLE;
          else state_s = ST_DONE;
        end
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    in_ready  = (state_r == ST_IDLE);
    out_valid = (state_r == ST_DONE);
    busy      = (state_r != ST_IDLE);
  end

endmodule
